// File: rtl/rx_pkt_ctrl_pkg.sv
// Shared receiver definitions: sequencer state encoding and timeout error codes.
package rx_pkt_ctrl_pkg;

   typedef enum logic [2:0] {
      StIdle  = 3'd0,
      StSync  = 3'd1,
      StCest  = 3'd2,
      StSig   = 3'd3,
      StPld   = 3'd4,
      StFlush = 3'd5
   } rx_state_e;

   localparam logic [1:0] ErrSync = 2'd0;
   localparam logic [1:0] ErrCest = 2'd1;
   localparam logic [1:0] ErrSig  = 2'd2;
   localparam logic [1:0] ErrPld  = 2'd3;

   localparam int unsigned CntW = 16;

endpackage

// File: rtl/rx_to_timer.sv
// Loadable down-counter used as the per-stage timeout of the packet sequencer.
module rx_to_timer #(
   parameter int unsigned W = 20
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load,
   input  logic [W-1:0] load_val,
   output logic         expired
);

   logic [W-1:0] cnt_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
      end else if (load) begin
         cnt_q <= load_val;
      end else if (cnt_q != '0) begin
         cnt_q <= cnt_q - 1'b1;
      end
   end

   // High in the last cycle of the window: the count reaches zero on the coming edge.
   assign expired = (cnt_q == W'(1));

endmodule

// File: rtl/rx_pkt_ctrl.sv
// Packet-level sequencer: tracks receiver milestones, enforces per-stage timeouts,
// flushes the datapath after every packet and keeps good/failed packet counters.
module rx_pkt_ctrl
   import rx_pkt_ctrl_pkg::*;
#(
   parameter int unsigned TO_W      = 20,
   parameter int unsigned SYNC_TO   = 4096,
   parameter int unsigned CEST_TO   = 2048,
   parameter int unsigned SIG_TO    = 8192,
   parameter int unsigned PLD_TO    = 600000,
   parameter int unsigned SIG_BITS  = 24,
   parameter int unsigned FLUSH_LEN = 16
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            enable,
   input  logic            packet_start,
   input  logic            max_indx_vld,
   input  logic            sigma2_vld,
   input  logic            signal_vld,
   input  logic            payload_done,
   output logic            chain_flush,
   output logic            busy,
   output logic [2:0]      state,
   output logic            pkt_ok,
   output logic            pkt_err,
   output logic [1:0]      err_code,
   output logic [CntW-1:0] pkt_cnt,
   output logic [CntW-1:0] err_cnt
);

   localparam int unsigned SigW = $clog2(SIG_BITS + 1);
   localparam int unsigned FlW  = $clog2(FLUSH_LEN + 1);

   rx_state_e       state_q, state_d;
   logic [SigW-1:0] sig_cnt_q, sig_cnt_d;
   logic [FlW-1:0]  flush_cnt_q, flush_cnt_d;
   logic            ok_d, err_d;
   logic [1:0]      err_code_q, err_code_d;
   logic [CntW-1:0] pkt_cnt_q, pkt_cnt_d, err_cnt_q, err_cnt_d;
   logic            chain_flush_q, busy_q, pkt_ok_q, pkt_err_q;
   logic            to_load, expired;
   logic [TO_W-1:0] to_val;

   rx_to_timer #(
      .W (TO_W)
   ) u_to_timer (
      .clk      (clk),
      .rst      (rst),
      .load     (to_load),
      .load_val (to_val),
      .expired  (expired)
   );

   // Priority inside a stage: abort, then the awaited event, then timeout.
   always_comb begin
      state_d     = state_q;
      sig_cnt_d   = sig_cnt_q;
      flush_cnt_d = flush_cnt_q;
      ok_d        = 1'b0;
      err_d       = 1'b0;
      err_code_d  = err_code_q;
      unique case (state_q)
         StIdle: begin
            if (packet_start && enable) state_d = StSync;
         end
         StSync: begin
            if (!enable) begin
               state_d = StFlush;
            end else if (max_indx_vld) begin
               state_d = StCest;
            end else if (expired) begin
               state_d    = StFlush;
               err_d      = 1'b1;
               err_code_d = ErrSync;
            end
         end
         StCest: begin
            if (!enable) begin
               state_d = StFlush;
            end else if (sigma2_vld) begin
               state_d = StSig;
            end else if (expired) begin
               state_d    = StFlush;
               err_d      = 1'b1;
               err_code_d = ErrCest;
            end
         end
         StSig: begin
            if (!enable) begin
               state_d = StFlush;
            end else if (signal_vld && (sig_cnt_q == SigW'(SIG_BITS - 1))) begin
               state_d = StPld;
            end else begin
               if (signal_vld) sig_cnt_d = sig_cnt_q + 1'b1;
               if (expired) begin
                  state_d    = StFlush;
                  err_d      = 1'b1;
                  err_code_d = ErrSig;
               end
            end
         end
         StPld: begin
            if (!enable) begin
               state_d = StFlush;
            end else if (payload_done) begin
               state_d = StFlush;
               ok_d    = 1'b1;
            end else if (expired) begin
               state_d    = StFlush;
               err_d      = 1'b1;
               err_code_d = ErrPld;
            end
         end
         StFlush: begin
            if (flush_cnt_q == FlW'(FLUSH_LEN - 1)) begin
               state_d = StIdle;
            end else begin
               flush_cnt_d = flush_cnt_q + 1'b1;
            end
         end
         default: state_d = StIdle;
      endcase
      if (state_d == StFlush && state_q != StFlush) flush_cnt_d = '0;
      if (state_d == StSig && state_q != StSig) sig_cnt_d = '0;
   end

   always_comb begin
      to_load = (state_d != state_q);
      to_val  = '0;
      unique case (state_d)
         StSync:  to_val = TO_W'(SYNC_TO);
         StCest:  to_val = TO_W'(CEST_TO);
         StSig:   to_val = TO_W'(SIG_TO);
         StPld:   to_val = TO_W'(PLD_TO);
         default: to_val = '0;
      endcase
   end

   always_comb begin
      pkt_cnt_d = pkt_cnt_q;
      err_cnt_d = err_cnt_q;
      if (ok_d && pkt_cnt_q != '1) pkt_cnt_d = pkt_cnt_q + 1'b1;
      if (err_d && err_cnt_q != '1) err_cnt_d = err_cnt_q + 1'b1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= StIdle;
         sig_cnt_q     <= '0;
         flush_cnt_q   <= '0;
         err_code_q    <= ErrSync;
         pkt_cnt_q     <= '0;
         err_cnt_q     <= '0;
         chain_flush_q <= 1'b0;
         busy_q        <= 1'b0;
         pkt_ok_q      <= 1'b0;
         pkt_err_q     <= 1'b0;
      end else begin
         state_q       <= state_d;
         sig_cnt_q     <= sig_cnt_d;
         flush_cnt_q   <= flush_cnt_d;
         err_code_q    <= err_code_d;
         pkt_cnt_q     <= pkt_cnt_d;
         err_cnt_q     <= err_cnt_d;
         chain_flush_q <= (state_d == StFlush);
         busy_q        <= (state_d != StIdle);
         pkt_ok_q      <= ok_d;
         pkt_err_q     <= err_d;
      end
   end

   assign state       = state_q;
   assign chain_flush = chain_flush_q;
   assign busy        = busy_q;
   assign pkt_ok      = pkt_ok_q;
   assign pkt_err     = pkt_err_q;
   assign err_code    = err_code_q;
   assign pkt_cnt     = pkt_cnt_q;
   assign err_cnt     = err_cnt_q;

endmodule

// File: tb/tb_rx_pkt_ctrl.sv
// Bench for rx_pkt_ctrl: per-cycle comparison against a stage/elapsed-time model plus
// directed scenarios with literal expectations.
module tb_rx_pkt_ctrl;

   localparam int unsigned SyncTo   = 4096;
   localparam int unsigned CestTo   = 300;
   localparam int unsigned SigTo    = 8192;
   localparam int unsigned PldTo    = 1500;
   localparam int unsigned SigBits  = 24;
   localparam int unsigned FlushLen = 16;

   logic        clk = 1'b0, rst = 1'b1, enable = 1'b0, packet_start = 1'b0;
   logic        max_indx_vld = 1'b0, sigma2_vld = 1'b0, signal_vld = 1'b0, payload_done = 1'b0;
   logic        chain_flush, busy, pkt_ok, pkt_err;
   logic [2:0]  state;
   logic [1:0]  err_code;
   logic [15:0] pkt_cnt, err_cnt;

   int checks = 0, failures = 0;

   always #5 clk = ~clk;

   rx_pkt_ctrl #(
      .TO_W      (20),
      .SYNC_TO   (SyncTo),
      .CEST_TO   (CestTo),
      .SIG_TO    (SigTo),
      .PLD_TO    (PldTo),
      .SIG_BITS  (SigBits),
      .FLUSH_LEN (FlushLen)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .enable       (enable),
      .packet_start (packet_start),
      .max_indx_vld (max_indx_vld),
      .sigma2_vld   (sigma2_vld),
      .signal_vld   (signal_vld),
      .payload_done (payload_done),
      .chain_flush  (chain_flush),
      .busy         (busy),
      .state        (state),
      .pkt_ok       (pkt_ok),
      .pkt_err      (pkt_err),
      .err_code     (err_code),
      .pkt_cnt      (pkt_cnt),
      .err_cnt      (err_cnt)
   );

   // Model: stage number, cycles spent in the stage, bits seen, flush cycles left.
   int m_stage = 0, m_el = 0, m_bits = 0, m_fl = 0, m_code = 0, m_pkt = 0, m_err = 0;
   bit m_ok = 0, m_perr = 0;

   function automatic int limit_of(input int s);
      case (s)
         1:       return SyncTo;
         2:       return CestTo;
         3:       return SigTo;
         default: return PldTo;
      endcase
   endfunction

   task automatic model_step();
      bit hit;
      m_ok   = 0;
      m_perr = 0;
      if (rst) begin
         m_stage = 0; m_el = 0; m_bits = 0; m_fl = 0; m_code = 0; m_pkt = 0; m_err = 0;
         return;
      end
      if (m_stage == 0) begin
         if (packet_start && enable) begin m_stage = 1; m_el = 0; end
      end else if (m_stage == 5) begin
         m_fl--;
         if (m_fl == 0) m_stage = 0;
      end else begin
         m_el++;
         if (m_stage == 3 && signal_vld) m_bits++;
         hit = (m_stage == 1 && max_indx_vld) || (m_stage == 2 && sigma2_vld) ||
               (m_stage == 3 && m_bits == SigBits) || (m_stage == 4 && payload_done);
         if (!enable) begin
            m_stage = 5; m_fl = FlushLen;
         end else if (hit) begin
            if (m_stage == 4) begin
               m_stage = 5; m_fl = FlushLen; m_ok = 1;
               if (m_pkt < 65535) m_pkt++;
            end else begin
               m_stage++; m_el = 0; m_bits = 0;
            end
         end else if (m_el == limit_of(m_stage)) begin
            m_code = m_stage - 1; m_perr = 1; m_stage = 5; m_fl = FlushLen;
            if (m_err < 65535) m_err++;
         end
      end
   endtask

   initial forever begin
      @(posedge clk or posedge rst);
      model_step();
   end

   // Per-cycle comparison and scenario statistics.
   logic [40:0] got_v, exp_v;
   int seen[$];
   int last_st = 0, fl_cycles = 0, ok_pulses = 0, err_pulses = 0;
   bit pld_seen = 0;

   initial forever begin
      @(negedge clk);
      if (!rst) begin
         got_v = {state, busy, chain_flush, pkt_ok, pkt_err, err_code, pkt_cnt, err_cnt};
         exp_v = {3'(m_stage), (m_stage != 0), (m_stage == 5), m_ok, m_perr, 2'(m_code),
                  16'(m_pkt), 16'(m_err)};
         checks++;
         if (got_v !== exp_v) begin
            failures++;
            $display("FAIL model_cycle t=%0t got=%h expected=%h", $time, got_v, exp_v);
         end
         if (int'(state) != last_st) begin seen.push_back(int'(state)); last_st = int'(state); end
         if (chain_flush) fl_cycles++;
         if (pkt_ok) ok_pulses++;
         if (pkt_err) err_pulses++;
         if (state == 3'd4) pld_seen = 1;
      end
   end

   task automatic chk(input string name, input longint got, input longint exp);
      checks++;
      if (got != exp) begin
         failures++;
         $display("FAIL %s: got %0d, expected %0d", name, got, exp);
      end
   endtask

   task automatic clear_stats();
      #1;
      seen.delete();
      last_st = int'(state);
      fl_cycles = 0; ok_pulses = 0; err_pulses = 0; pld_seen = 0;
   endtask

   task automatic pulse(input int which);
      case (which)
         0: packet_start = 1'b1;
         1: max_indx_vld = 1'b1;
         2: sigma2_vld   = 1'b1;
         3: signal_vld   = 1'b1;
         default: payload_done = 1'b1;
      endcase
      @(negedge clk);
      packet_start = 1'b0; max_indx_vld = 1'b0; sigma2_vld = 1'b0;
      signal_vld = 1'b0; payload_done = 1'b0;
   endtask

   task automatic wait_state(input int s, input int budget, output int n);
      n = 0;
      while (int'(state) != s && n < budget) begin @(negedge clk); n++; end
      chk($sformatf("wait_state_%0d", s), longint'(state), s);
   endtask

   task automatic run_nominal(input int exp_pkt);
      int n;
      int exp_seq[6] = '{1, 2, 3, 4, 5, 0};
      bit seq_ok;
      clear_stats();
      pulse(0);
      repeat (99) @(negedge clk);
      pulse(1);
      repeat (199) @(negedge clk);
      pulse(2);
      repeat (SigBits) begin @(negedge clk); pulse(3); end
      repeat (999) @(negedge clk);
      pulse(4);
      chk("nom_pkt_ok", pkt_ok, 1);
      wait_state(0, 100, n);
      #1;
      seq_ok = (seen.size() == 6);
      if (seq_ok) for (int i = 0; i < 6; i++) if (seen[i] != exp_seq[i]) seq_ok = 0;
      chk("nom_state_walk", seq_ok, 1);
      chk("nom_flush_cycles", fl_cycles, 16);
      chk("nom_ok_pulses", ok_pulses, 1);
      chk("nom_pkt_cnt", pkt_cnt, exp_pkt);
   endtask

   initial begin
      int n;
      repeat (3) @(negedge clk);
      #1;
      chk("reset_outputs", {state, busy, chain_flush, pkt_ok, pkt_err, err_code, pkt_cnt, err_cnt}, 0);
      rst = 1'b0;
      enable = 1'b1;
      @(negedge clk);
      chk("idle_state", state, 0);

      run_nominal(1);

      // Sync timeout.
      pulse(0);
      wait_state(5, 5000, n);
      chk("sync_to_cycles", n, 4096);
      chk("sync_to_pkt_err", pkt_err, 1);
      chk("sync_to_err_code", err_code, 0);
      chk("sync_to_err_cnt", err_cnt, 1);
      wait_state(0, 100, n);

      // Short signal field.
      clear_stats();
      pulse(0); pulse(1); pulse(2);
      repeat (SigBits - 1) pulse(3);
      wait_state(5, SigTo + 10, n);
      chk("sig_to_cycles", n, SigTo - (SigBits - 1));
      chk("sig_to_err_code", err_code, 2);
      chk("sig_to_err_cnt", err_cnt, 2);
      #1;
      chk("sig_to_no_pld", pld_seen, 0);
      wait_state(0, 100, n);

      // payload_done lands on the cycle the PLD timer expires.
      pulse(0); pulse(1); pulse(2);
      repeat (SigBits) pulse(3);
      repeat (PldTo - 1) @(negedge clk);
      pulse(4);
      chk("edge_state", state, 5);
      chk("edge_pkt_ok", pkt_ok, 1);
      chk("edge_pkt_err", pkt_err, 0);
      chk("edge_pkt_cnt", pkt_cnt, 2);
      wait_state(0, 100, n);

      // Enable dropped in CEST, then ignored starts.
      clear_stats();
      pulse(0); pulse(1);
      chk("abort_in_cest", state, 2);
      enable = 1'b0;
      @(negedge clk);
      chk("abort_flush", state, 5);
      enable = 1'b1;
      pulse(0);
      wait_state(0, 100, n);
      #1;
      chk("abort_no_strobes", ok_pulses + err_pulses, 0);
      chk("abort_flush_cycles", fl_cycles, 16);
      enable = 1'b0;
      pulse(0);
      repeat (3) @(negedge clk);
      chk("disabled_start_ignored", state, 0);
      enable = 1'b1;
      chk("abort_pkt_cnt", pkt_cnt, 2);
      chk("abort_err_cnt", err_cnt, 2);

      // Reset in PLD.
      pulse(0); pulse(1); pulse(2);
      repeat (SigBits) pulse(3);
      repeat (10) @(negedge clk);
      chk("rst_in_pld", state, 4);
      #2 rst = 1'b1;
      #1;
      chk("rst_async_outputs",
          {state, busy, chain_flush, pkt_ok, pkt_err, err_code, pkt_cnt, err_cnt}, 0);
      @(negedge clk);
      #2 rst = 1'b0;
      @(negedge clk);
      run_nominal(1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/rx_pkt_ctrl.md
# rx_pkt_ctrl

Packet-level sequencer for the OFDM receiver chain. It watches the per-stage milestone strobes: packet detect, symbol sync, channel/noise estimation, signal-field decode and LDPC payload decode. It enforces a per-stage timeout and issues a synchronous flush to the datapath after every packet, good or failed. It sits beside the receiver top level, taking status strobes from the chain and driving `chain_flush` plus status/counter outputs for software.

## Interface
Parameters:
- `TO_W`, default 20: width of the timeout counter.
- `SYNC_TO`, default 4096: cycles allowed from packet detect to `max_indx_vld`.
- `CEST_TO`, default 2048: cycles allowed from sync to `sigma2_vld`.
- `SIG_TO`, default 8192: cycles allowed from estimation to completion of the signal field.
- `PLD_TO`, default 600000: cycles allowed from signal field to `payload_done`.
- `SIG_BITS`, default 24: number of `signal_vld` strobes that make one signal field.
- `FLUSH_LEN`, default 16: cycles `chain_flush` stays high.

Ports (clock and reset first):
- `clk`  in  1  working clock.
- `rst`  in  1  reset, asynchronous, active-high.
- `enable`  in  1  software enable; when low, new packets are not accepted.
- `packet_start`  in  1  single-cycle strobe from packet detect.
- `max_indx_vld`  in  1  single-cycle strobe, symbol sync found.
- `sigma2_vld`  in  1  single-cycle strobe, noise estimate ready (estimation complete).
- `signal_vld`  in  1  one strobe per decoded signal bit.
- `payload_done`  in  1  single-cycle strobe, LDPC frame finished.
- `chain_flush`  out  1  synchronous clear for datapath stages.
- `busy`  out  1  high in any state other than IDLE.
- `state`  out  3  current FSM state encoding.
- `pkt_ok`  out  1  one-cycle strobe, packet completed.
- `pkt_err`  out  1  one-cycle strobe, packet timed out.
- `err_code`  out  2  stage that timed out: 0 SYNC, 1 CEST, 2 SIG, 3 PLD. Held until the next `pkt_err`.
- `pkt_cnt`  out  16  count of good packets, saturating.
- `err_cnt`  out  16  count of failed packets, saturating.

## Operation
- State encoding: IDLE=0, SYNC=1, CEST=2, SIG=3, PLD=4, FLUSH=5.
- IDLE:
  - `packet_start` with `enable`=1 → SYNC.
  - `packet_start` with `enable`=0 is ignored.
- SYNC: `max_indx_vld` → CEST.
- CEST: `sigma2_vld` → SIG.
- SIG: counts `signal_vld` strobes. When the count reaches `SIG_BITS` → PLD.
- PLD: `payload_done` → FLUSH, with `pkt_ok` asserted.
- Timeout counter:
  - Reloaded with the stage limit on entry to each of SYNC/CEST/SIG/PLD.
  - Decrements every cycle.
  - Reaching 0 before the awaited event → FLUSH, with `pkt_err` asserted and `err_code` set to that stage.
- Simultaneous awaited event and timeout expiry in the same cycle: the event wins, no error.
- `enable` falling while in SYNC..PLD: abort → FLUSH with neither `pkt_ok` nor `pkt_err`, and counters unchanged.
- FLUSH:
  - `chain_flush` high for exactly `FLUSH_LEN` cycles, then → IDLE.
  - `packet_start` during FLUSH is ignored.
- `packet_start` in SYNC..PLD is ignored; it does not restart the packet.
- Strobes that arrive out of order, e.g. `payload_done` in SYNC, are ignored.
- The SIG bit counter clears on entry to SIG.
- `pkt_cnt` and `err_cnt` saturate at 0xFFFF.

## Timing
- Reset values:
  - FSM in IDLE.
  - `chain_flush`, `busy`, `pkt_ok`, `pkt_err` = 0.
  - `state` = 0, `err_code` = 0, `pkt_cnt` = 0, `err_cnt` = 0.
  - Internal counters = 0.
- All outputs are registered. A strobe sampled at edge N changes `state` at edge N, visible in cycle N+1.
- `pkt_ok` and `pkt_err` are high in the first FLUSH cycle. `pkt_cnt`/`err_cnt` update in that same cycle.
- `chain_flush` rises in the first FLUSH cycle and falls on the edge that returns the FSM to IDLE.
- `busy` = (`state` != IDLE).
- After the last FLUSH cycle, the earliest packet that can be accepted is a `packet_start` in the following cycle, i.e. IDLE's first cycle.
- A timeout of limit L fires at the L-th cycle after stage entry if the event has not been seen.
- Reset mid-packet returns everything to reset values immediately. `chain_flush` is not pulsed; the datapath uses `rst` directly.

## Structure
- Shared receiver package: state encoding constants (IDLE..FLUSH) and `err_code` constants (ERR_SYNC..ERR_PLD).
- One sub-module is natural: `rx_to_timer`, a loadable down-counter with load value, load strobe and `expired` flag, instanced once and reloaded per stage.
- Milestone counters and status registers live in `rx_pkt_ctrl`.

## Test plan
- Nominal packet: `packet_start`, `max_indx_vld` 100 cycles later, `sigma2_vld` +200, 24 `signal_vld` strobes, `payload_done` +1000 → `state` walks 1,2,3,4,5,0; `pkt_ok` pulses once; `pkt_cnt`=1; `chain_flush` high for 16 cycles.
- Sync timeout, `SYNC_TO`=4096 with no `max_indx_vld` → FLUSH entered 4096 cycles after SYNC entry; `pkt_err`=1; `err_code`=0; `err_cnt`=1.
- Short signal field: 23 `signal_vld` strobes then silence → timeout in SIG; `err_code`=2; PLD never entered.
- `payload_done` on the exact cycle the PLD timer expires → `pkt_ok`=1, `pkt_err`=0.
- `enable` dropped during CEST → FLUSH with no strobes and counters unchanged; a `packet_start` during FLUSH or with `enable`=0 is ignored.
- `rst` asserted in PLD → all outputs at reset values in the next cycle; a subsequent nominal packet completes normally.
